branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 192 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Tracks in-flight conditional-branch predictions made at fetch and checks
// them against the resolved outcome from EX. A match pops the oldest
// prediction. A mismatch squashes the front end for two cycles and redirects
// fetch to the correct path. Every accepted resolution is reported to the
// predictor one cycle later.
//
// Optional feature: define BRU_STATS_EN to add wrapping 32-bit counters of
// resolved branches and mispredictions.
//
// Ports
//   clk              pipeline clock, rising edge
//   rst              asynchronous active-high reset
//   pred_valid       fetch pushes a prediction record {pred_pc, pred_taken}
//   pred_pc          PC of the predicted branch
//   pred_taken       predicted direction (1 = taken)
//   ex_valid         EX resolves a conditional branch this cycle
//   ex_pc            PC of the resolving branch
//   ex_taken         resolved direction (1 = taken)
//   ex_target        computed taken target
//   branch_EX_done   one-cycle pulse: a resolution is reported to the predictor
//   actual_outcome   resolved direction, valid while branch_EX_done = 1
//   PC_prev          PC of the resolved branch, valid while branch_EX_done = 1
//   flush            squash IF/ID and fetch from redirect_pc
//   redirect_pc      correct-path fetch address, valid while flush = 1
//   stall_fetch      prediction FIFO is full
//   stat_branches    (BRU_STATS_EN) count of accepted resolutions
//   stat_mispredicts (BRU_STATS_EN) count of mispredictions
// -----------------------------------------------------------------------------
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        branch_EX_done,
    output logic        actual_outcome,
    output logic [31:0] PC_prev,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        stall_fetch
`ifdef BRU_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        flush_cnt;      // 0 in the first FLUSH cycle, 1 in the second

    // Prediction FIFO
    logic [31:0] fifo_pc    [4];
    logic        fifo_taken [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;

    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] head_pc;
    logic        head_taken;
    logic        resolve;
    logic        mismatch;
    logic        clear;
    logic        pop;
    logic        push;
    logic [31:0] redirect_next;

    assign fifo_empty  = (count == 3'd0);
    assign fifo_full   = (count == 3'd4);
    assign stall_fetch = fifo_full;

    // An empty FIFO presents a not-taken head; the empty term of the
    // mismatch already covers that case, so the stale head PC is harmless.
    assign head_pc    = fifo_pc[rd_ptr];
    assign head_taken = fifo_empty ? 1'b0 : fifo_taken[rd_ptr];

    // Inputs are only honoured in IDLE; FLUSH ignores both ports.
    assign resolve  = (state == IDLE) && ex_valid;
    assign mismatch = fifo_empty || (head_pc != ex_pc) || (head_taken != ex_taken);
    assign clear    = resolve && mismatch;
    assign pop      = resolve && !mismatch;
    // Full is judged on the current count, so a push alongside a pop at full
    // is still rejected; the clear on a mismatch wins over any push.
    assign push     = (state == IDLE) && pred_valid && !fifo_full && !clear;

    // NOTE: the record storage has no reset; pointers and count decide what
    // is valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pred_pc;
            fifo_taken[wr_ptr] <= pred_taken;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (clear) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= (state == FLUSH) && !flush_cnt;
        end
    end

    // FSM: next-state logic
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear)     state_next = FLUSH;
            FLUSH:   if (flush_cnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        flush         = (state == FLUSH);
        redirect_next = ex_taken ? ex_target : ex_pc + 32'd4;
    end

    // Resolution report and redirect address, one cycle after the EX cycle.
    // actual_outcome / PC_prev / redirect_pc hold between events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_EX_done <= 1'b0;
            actual_outcome <= 1'b0;
            PC_prev        <= 32'd0;
            redirect_pc    <= 32'd0;
        end else begin
            branch_EX_done <= resolve;
            if (resolve) begin
                actual_outcome <= ex_taken;
                PC_prev        <= ex_pc;
            end
            if (clear) begin
                redirect_pc <= redirect_next;
            end
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (resolve) stat_branches    <= stat_branches + 32'd1;
            if (clear)   stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed scenarios followed by random traffic. A queue-based reference
// model of in-flight predictions supplies every expected value; outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = 32'd0;
    logic        pred_taken = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        branch_EX_done;
    logic        actual_outcome;
    logic [31:0] PC_prev;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stall_fetch;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .branch_EX_done (branch_EX_done),
        .actual_outcome (actual_outcome),
        .PC_prev        (PC_prev),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .stall_fetch    (stall_fetch)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Reference model: list of outstanding predictions plus flush countdown.
    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } rec_t;

    rec_t        q[$];
    int          flush_left = 0;
    logic        m_done = 1'b0;
    logic        m_out = 1'b0;
    logic [31:0] m_prev = 32'd0;
    logic [31:0] m_redir = 32'd0;
    logic [31:0] m_branches = 32'd0;
    logic [31:0] m_mispred = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit pv, input logic [31:0] ppc, input bit pt,
                              input bit ev, input logic [31:0] epc, input bit et,
                              input logic [31:0] etgt);
        bit was_full;
        bit miss;
        was_full = (q.size() == 4);
        m_done   = 1'b0;
        if (flush_left > 0) begin
            flush_left--;
        end else if (ev) begin
            m_done = 1'b1;
            m_out  = et;
            m_prev = epc;
            m_branches++;
            if (q.size() == 0) miss = 1'b1;
            else               miss = (q[0].pc != epc) || (q[0].taken != et);
            if (miss) begin
                q.delete();
                m_redir    = et ? etgt : epc + 32'd4;
                flush_left = 2;
                m_mispred++;
            end else begin
                void'(q.pop_front());
                if (pv && !was_full) q.push_back('{pc: ppc, taken: pt});
            end
        end else if (pv && !was_full) begin
            q.push_back('{pc: ppc, taken: pt});
        end
    endtask

    task automatic check_all();
        check("done", 32'(branch_EX_done), 32'(m_done));
        if (m_done) begin
            check("outcome", 32'(actual_outcome), 32'(m_out));
            check("pc_prev", PC_prev, m_prev);
        end
        check("flush", 32'(flush), 32'(flush_left > 0));
        if (flush_left > 0) check("redirect", redirect_pc, m_redir);
        check("stall", 32'(stall_fetch), 32'(q.size() == 4));
`ifdef BRU_STATS_EN
        check("stat_br", stat_branches, m_branches);
        check("stat_mis", stat_mispredicts, m_mispred);
`endif
    endtask

    // One clock: drive inputs, advance model, clock, sample 1 ns later.
    task automatic cycle(input bit pv, input logic [31:0] ppc, input bit pt,
                         input bit ev, input logic [31:0] epc, input bit et,
                         input logic [31:0] etgt);
        pred_valid = pv;
        pred_pc    = ppc;
        pred_taken = pt;
        ex_valid   = ev;
        ex_pc      = epc;
        ex_taken   = et;
        ex_target  = etgt;
        model_step(pv, ppc, pt, ev, epc, et, etgt);
        @(posedge clk);
        #1;
        check_all();
        pred_valid = 1'b0;
        ex_valid   = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic push(input logic [31:0] pc, input bit t);
        cycle(1'b1, pc, t, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, pc, t, tgt);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst        = 1'b1;
        pred_valid = 1'b0;
        ex_valid   = 1'b0;
        q.delete();
        flush_left = 0;
        m_done     = 1'b0;
        m_branches = 32'd0;
        m_mispred  = 32'd0;
        #1;
        check("rst_done", 32'(branch_EX_done), 32'd0);
        check("rst_outcome", 32'(actual_outcome), 32'd0);
        check("rst_pc_prev", PC_prev, 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_stall", 32'(stall_fetch), 32'd0);
`ifdef BRU_STATS_EN
        check("rst_stat_br", stat_branches, 32'd0);
        check("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          r_pv;
        bit          r_pt;
        bit          r_ev;
        bit          r_et;
        logic [31:0] r_ppc;
        logic [31:0] r_epc;
        logic [31:0] r_tgt;

        repeat (2) @(posedge clk);
        do_reset();

        // Match
        push(32'h100, 1'b1);
        resolve(32'h100, 1'b1, 32'h0);
        check("match_done", 32'(branch_EX_done), 32'd1);
        check("match_outcome", 32'(actual_outcome), 32'd1);
        check("match_pc_prev", PC_prev, 32'h100);
        check("match_flush", 32'(flush), 32'd0);

        // Direction mispredict: predicted taken, resolved not taken
        push(32'h200, 1'b1);
        resolve(32'h200, 1'b0, 32'h0);
        check("dir_flush", 32'(flush), 32'd1);
        check("dir_redirect", redirect_pc, 32'h204);
        idle();
        check("dir_flush_hold", 32'(flush), 32'd1);
        check("dir_redirect_hold", redirect_pc, 32'h204);
        idle();
        check("dir_flush_end", 32'(flush), 32'd0);

        // Taken mispredict
        push(32'h300, 1'b0);
        resolve(32'h300, 1'b1, 32'h400);
        check("tkn_redirect", redirect_pc, 32'h400);
        idle();
        idle();

        // Fall-through wraps to zero
        push(32'hFFFF_FFFC, 1'b1);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
        check("wrap_redirect", redirect_pc, 32'h0);
        idle();
        idle();

        // Full FIFO: five pushes, fifth dropped
        for (int i = 0; i < 5; i++) begin
            push(32'h1000 + 32'(i) * 32'h10, 1'(i % 2));
            if (i == 3) check("full_stall", 32'(stall_fetch), 32'd1);
        end
        // Push + matching pop at full: push rejected, pop performed
        cycle(1'b1, 32'h2000, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0);
        check("full_pop_stall", 32'(stall_fetch), 32'd0);
        // Push + matching pop below full: both take effect
        cycle(1'b1, 32'h2000, 1'b1, 1'b1, 32'h1010, 1'b1, 32'h0);
        resolve(32'h1020, 1'b0, 32'h0);
        resolve(32'h1030, 1'b1, 32'h0);
        resolve(32'h2000, 1'b1, 32'h0);
        check("full_last_flush", 32'(flush), 32'd0);
        check("full_last_pc", PC_prev, 32'h2000);

        // Empty resolve, then inputs ignored during the flush window
        resolve(32'h480, 1'b1, 32'h500);
        check("empty_flush", 32'(flush), 32'd1);
        check("empty_redirect", redirect_pc, 32'h500);
        cycle(1'b1, 32'h900, 1'b1, 1'b1, 32'h999, 1'b1, 32'h0);
        check("flushwin_done", 32'(branch_EX_done), 32'd0);
        idle();
        idle();

        // Reset in the middle of a flush
        push(32'h600, 1'b1);
        resolve(32'h600, 1'b0, 32'h0);
        do_reset();
        resolve(32'h800, 1'b0, 32'h0);
        check("post_rst_done", 32'(branch_EX_done), 32'd1);
        check("post_rst_redirect", redirect_pc, 32'h804);
        idle();
        idle();

        // Random traffic, biased towards matching resolutions
        for (int i = 0; i < 400; i++) begin
            r_pv  = 1'($urandom_range(0, 1));
            r_ppc = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
            r_pt  = 1'($urandom_range(0, 1));
            r_ev  = ($urandom_range(0, 2) == 0);
            r_tgt = 32'h8000 + 32'($urandom_range(0, 255)) * 32'd4;
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                r_epc = q[0].pc;
                r_et  = q[0].taken;
            end else begin
                r_epc = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
                r_et  = 1'($urandom_range(0, 1));
            end
            cycle(r_pv, r_ppc, r_pt, r_ev, r_epc, r_et, r_tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
